// File: rtl/fma_issue_sched_pkg.sv
// rtl/fma_issue_sched_pkg.sv - shared widths, scheduler state encoding and operand classification
package fma_issue_sched_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_EXP_WIDTH = 8;
    localparam int DEF_SIG_WIDTH = 23;
    localparam int DEF_TAG_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ISSUE = 2'd3
    } sched_state_t;

    // Zero exponent with a nonzero fraction; zeros, Inf and NaN are not flagged.
    function automatic logic is_subnormal(input logic [63:0] word, input int exp_w, input int sig_w);
        logic [63:0] frac_mask;
        logic [63:0] exp_mask;
        frac_mask = (64'd1 << sig_w) - 64'd1;
        exp_mask  = ((64'd1 << exp_w) - 64'd1) << sig_w;
        return ((word & exp_mask) == 64'd0) && ((word & frac_mask) != 64'd0);
    endfunction

endpackage

// File: rtl/fma_res_fifo.sv
// rtl/fma_res_fifo.sv - first-word-fall-through result FIFO with occupancy count
module fma_res_fifo #(
    parameter int DATA_WIDTH = 36,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign rdata = mem[rd_ptr];

    // Push while full is legal only together with a pop; the scheduler's credit enforces it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fma_issue_sched.sv
// rtl/fma_issue_sched.sv - FMA front-end: operand capture, pre-normalisation slot, credit-gated issue, tagged results
module fma_issue_sched
    import fma_issue_sched_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int EXP_WIDTH  = DEF_EXP_WIDTH,
    parameter int SIG_WIDTH  = DEF_SIG_WIDTH,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
    parameter int PIPE_DEPTH = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [WIDTH-1:0]     in_c,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic [WIDTH-1:0]     dp_a,
    output logic [WIDTH-1:0]     dp_b,
    output logic [WIDTH-1:0]     dp_c,
    output logic [2:0]           dp_sub_mask,
    output logic                 dp_norm_en,
    output logic                 dp_issue,
    input  logic [WIDTH-1:0]     dp_res,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_res,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    sched_state_t               state;
    logic [TAG_WIDTH-1:0]       tag_q;
    logic [2:0]                 in_mask;
    logic [CNT_W-1:0]           outstanding;
    logic [CNT_W-1:0]           fifo_count;
    logic                       has_credit;
    logic                       pop;
    logic [PIPE_DEPTH-1:0]      pipe_valid;
    logic [TAG_WIDTH-1:0]       pipe_tag [PIPE_DEPTH];
    logic [WIDTH+TAG_WIDTH-1:0] fifo_rdata;

    assign in_mask = {is_subnormal(64'(in_a), EXP_WIDTH, SIG_WIDTH),
                      is_subnormal(64'(in_b), EXP_WIDTH, SIG_WIDTH),
                      is_subnormal(64'(in_c), EXP_WIDTH, SIG_WIDTH)};

    // Outstanding counts ops in flight plus results buffered, so credit is FIFO_DEPTH minus it.
    assign has_credit = outstanding < CNT_W'(FIFO_DEPTH);
    assign in_ready   = (state == ST_IDLE) && !rst;
    assign dp_issue   = ((state == ST_ISSUE) || (state == ST_WAIT)) && has_credit;
    assign pop        = out_valid && out_ready;
    assign out_valid  = (fifo_count != '0);
    assign out_res    = fifo_rdata[WIDTH+TAG_WIDTH-1:TAG_WIDTH];
    assign out_tag    = fifo_rdata[TAG_WIDTH-1:0];
    assign busy       = (state != ST_IDLE) || (outstanding != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            dp_a        <= '0;
            dp_b        <= '0;
            dp_c        <= '0;
            dp_sub_mask <= '0;
            dp_norm_en  <= 1'b0;
            tag_q       <= '0;
        end else begin
            dp_norm_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        dp_a        <= in_a;
                        dp_b        <= in_b;
                        dp_c        <= in_c;
                        tag_q       <= in_tag;
                        dp_sub_mask <= in_mask;
                        dp_norm_en  <= |in_mask;
                        state       <= (|in_mask) ? ST_NORM : ST_ISSUE;
                    end
                end
                ST_NORM:  state <= ST_ISSUE;
                ST_ISSUE: state <= has_credit ? ST_IDLE : ST_WAIT;
                ST_WAIT:  if (has_credit) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({dp_issue, pop})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Tag pipe mirrors the datapath latency; clearing the valids drops results of ops issued before reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= dp_issue;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
        pipe_tag[0] <= tag_q;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            pipe_tag[i] <= pipe_tag[i-1];
        end
    end

    fma_res_fifo #(
        .DATA_WIDTH (WIDTH + TAG_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pipe_valid[PIPE_DEPTH-1]),
        .wdata ({dp_res, pipe_tag[PIPE_DEPTH-1]}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_fma_issue_sched.sv
// tb/tb_fma_issue_sched.sv - self-checking bench for fma_issue_sched
module tb_fma_issue_sched;

    localparam int P  = 4;
    localparam int FD = 4;

    logic        clk, rst, in_valid, in_ready;
    logic [31:0] in_a, in_b, in_c;
    logic [3:0]  in_tag;
    logic [31:0] dp_a, dp_b, dp_c, dp_res;
    logic [2:0]  dp_sub_mask;
    logic        dp_norm_en, dp_issue;
    logic        out_valid, out_ready, busy;
    logic [31:0] out_res;
    logic [3:0]  out_tag;

    fma_issue_sched #(
        .WIDTH(32), .EXP_WIDTH(8), .SIG_WIDTH(23), .TAG_WIDTH(4),
        .PIPE_DEPTH(P), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_tag(in_tag),
        .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_sub_mask(dp_sub_mask),
        .dp_norm_en(dp_norm_en), .dp_issue(dp_issue), .dp_res(dp_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_tag(out_tag), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit started = 0;
    int issue_cnt = 0;
    int deliv_cnt = 0;

    bit          sched_v [16];
    logic [31:0] sched_d [16];

    // Reference model state: one pending request, outstanding credit use, in-flight and buffered results.
    typedef struct {
        int          land;
        logic [31:0] res;
        logic [3:0]  tag;
    } inf_t;
    inf_t        inflight[$];
    logic [35:0] mfifo[$];
    bit          pending = 0;
    logic [31:0] p_a, p_b, p_c;
    logic [3:0]  p_tag;
    logic [2:0]  p_mask;
    int          p_acc, p_earliest;
    int          outstanding = 0;

    function automatic logic [31:0] res_fn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a ^ {b[15:0], b[31:16]}) + c;
    endfunction

    function automatic bit sub(input logic [31:0] w);
        return (w[30:23] == 8'd0) && (w[22:0] != 23'd0);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in datapath: returns res_fn of the issued operands exactly P cycles after dp_issue.
    always @(posedge clk) begin
        #1;
        if (sched_v[cyc % 16]) begin
            dp_res = sched_d[cyc % 16];
            sched_v[cyc % 16] = 0;
        end else begin
            dp_res = 32'hBAD0_0000 | 32'(cyc);
        end
    end

    always @(negedge clk) begin
        bit exp_ready, exp_issue, exp_norm, exp_valid;
        if (dp_issue === 1'b1) begin
            sched_v[(cyc + P) % 16] = 1;
            sched_d[(cyc + P) % 16] = res_fn(dp_a, dp_b, dp_c);
            issue_cnt++;
        end
        if (out_valid === 1'b1 && out_ready) deliv_cnt++;
        if (started) begin
            exp_ready = !rst && !pending;
            exp_issue = pending && (cyc >= p_earliest) && (outstanding < FD);
            exp_norm  = pending && (p_mask != 3'd0) && (cyc == p_acc + 1);
            exp_valid = mfifo.size() > 0;
            chk("in_ready", in_ready, exp_ready);
            chk("dp_issue", dp_issue, exp_issue);
            chk("dp_norm_en", dp_norm_en, exp_norm);
            chk("busy", busy, pending || outstanding != 0);
            chk("out_valid", out_valid, exp_valid);
            if (exp_valid) begin
                chk("out_res", out_res, mfifo[0][35:4]);
                chk("out_tag", out_tag, mfifo[0][3:0]);
            end
            if (pending) begin
                chk("dp_a", dp_a, p_a);
                chk("dp_b", dp_b, p_b);
                chk("dp_c", dp_c, p_c);
                chk("dp_sub_mask", dp_sub_mask, p_mask);
            end
            if (rst) begin
                pending = 0;
                outstanding = 0;
                mfifo.delete();
                inflight.delete();
            end else begin
                if (exp_valid && out_ready) begin
                    void'(mfifo.pop_front());
                    outstanding--;
                end
                if (inflight.size() > 0 && inflight[0].land == cyc) begin
                    mfifo.push_back({inflight[0].res, inflight[0].tag});
                    void'(inflight.pop_front());
                end
                if (exp_issue) begin
                    inflight.push_back('{cyc + P, res_fn(p_a, p_b, p_c), p_tag});
                    outstanding++;
                    pending = 0;
                end
                if (in_valid && exp_ready) begin
                    pending = 1;
                    p_a = in_a; p_b = in_b; p_c = in_c; p_tag = in_tag;
                    p_mask = {sub(in_a), sub(in_b), sub(in_c)};
                    p_acc = cyc;
                    p_earliest = cyc + ((p_mask != 3'd0) ? 2 : 1);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [3:0] t);
        bit got = 0;
        in_valid = 1; in_a = a; in_b = b; in_c = c; in_tag = t;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            got = (in_ready === 1'b1);
            step();
            if (got) break;
        end
        in_valid = 0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL send_timeout: request tag %0d not accepted within 100 cycles", t);
        end
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (busy === 1'b0) begin
                idle = 1;
                break;
            end
        end
        checks++;
        if (!idle) begin
            errors++;
            $display("FAIL idle_timeout: busy still high after 300 cycles");
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int i0, d0, t_iss, tgt;
        int iss_c [8];
        bit seen;
        rst = 1; in_valid = 0; in_a = 0; in_b = 0; in_c = 0; in_tag = 0; out_ready = 1; dp_res = 0;
        for (int i = 0; i < 16; i++) begin
            sched_v[i] = 0;
            sched_d[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1 started = 1;
        at_sample();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dp_issue", dp_issue, 0);
        chk("rst_dp_norm_en", dp_norm_en, 0);
        chk("rst_dp_a", dp_a, 0);
        chk("rst_dp_sub_mask", dp_sub_mask, 0);
        step();
        rst = 0;
        at_sample();
        chk("post_rst_in_ready", in_ready, 1);
        step();

        // Normal op
        send(32'h3F800000, 32'h40000000, 32'h3F800000, 4'd3);
        at_sample();
        chk("norm_issue_c1", dp_issue, 1);
        chk("norm_in_ready_c1", in_ready, 0);
        chk("norm_no_norm_en", dp_norm_en, 0);
        t_iss = cyc;
        at_sample();
        chk("norm_in_ready_c2", in_ready, 1);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            at_sample();
            if (out_valid === 1'b1) begin
                seen = 1;
                break;
            end
        end
        chk("norm_out_valid_seen", seen, 1);
        chk("norm_out_latency", cyc - t_iss, P + 1);
        chk("norm_out_res", out_res, 32'h7F004000);
        chk("norm_out_tag", out_tag, 3);
        step();
        wait_idle();

        // Subnormal C
        send(32'h3F800000, 32'h40000000, 32'h00000001, 4'd5);
        at_sample();
        chk("sub_mask", dp_sub_mask, 3'b001);
        chk("sub_norm_en_c1", dp_norm_en, 1);
        chk("sub_no_issue_c1", dp_issue, 0);
        at_sample();
        chk("sub_issue_c2", dp_issue, 1);
        step();
        wait_idle();

        // Subnormal A and negative subnormal B, Inf C
        send(32'h00000010, 32'h80000001, 32'h7F800000, 4'd6);
        at_sample();
        chk("sub2_mask", dp_sub_mask, 3'b110);
        chk("sub2_norm_en", dp_norm_en, 1);
        step();
        wait_idle();

        // Zero / NaN / Inf operands are not subnormal
        send(32'h7FC00000, 32'h80000000, 32'h00000000, 4'd7);
        at_sample();
        chk("zero_mask", dp_sub_mask, 3'b000);
        chk("zero_issue_c1", dp_issue, 1);
        step();
        wait_idle();

        // Backpressure: FIFO_DEPTH issues, fifth op parks
        out_ready = 0;
        i0 = issue_cnt;
        d0 = deliv_cnt;
        for (int k = 0; k < 5; k++) begin
            send(32'h3F800000 + k, 32'h40000000 ^ (k << 8), (k == 2) ? 32'h00000003 : 32'h3F000000, 4'(k));
        end
        repeat (6) step();
        chk("bp_issue_count", issue_cnt - i0, 4);
        chk("bp_in_ready_parked", in_ready, 0);
        in_valid = 1; in_a = 32'h41000000; in_b = 32'h41100000; in_c = 32'h41200000; in_tag = 4'd5;
        for (int k = 0; k < 3; k++) begin
            at_sample();
            chk("bp_sixth_blocked", in_ready, 0);
            step();
        end
        in_valid = 0;
        out_ready = 1;
        step();
        out_ready = 0;
        at_sample();
        step();
        at_sample();
        chk("bp_fifth_issue", issue_cnt - i0, 5);
        step();
        out_ready = 1;
        send(32'h41000000, 32'h41100000, 32'h41200000, 4'd5);
        wait_idle();
        chk("bp_delivered", deliv_cnt - d0, 6);

        // Result lands in the same cycle as a pop with three entries buffered
        out_ready = 0;
        d0 = deliv_cnt;
        for (int k = 0; k < 4; k++) begin
            send(32'h40400000 + (k << 4), 32'h3F000000, 32'h00800000, 4'(8 + k));
        end
        tgt = cyc + P;
        for (int k = 0; k < 20 && cyc != tgt; k++) step();
        out_ready = 1;
        step();
        out_ready = 0;
        at_sample();
        chk("pp_one_popped", deliv_cnt - d0, 1);
        chk("pp_out_valid", out_valid, 1);
        step();
        send(32'h40A00000, 32'h40C00000, 32'h40E00000, 4'd12);
        at_sample();
        chk("pp_credit_issue", dp_issue, 1);
        step();
        out_ready = 1;
        wait_idle();
        chk("pp_delivered", deliv_cnt - d0, 5);

        // Reset mid-flight: one buffered, two in flight
        out_ready = 0;
        send(32'h3F800000, 32'h3F800000, 32'h3F800000, 4'd1);
        repeat (P + 3) step();
        send(32'h40000000, 32'h40000000, 32'h40000000, 4'd2);
        send(32'h40400000, 32'h40400000, 32'h40400000, 4'd3);
        step();
        rst = 1;
        step();
        rst = 0;
        at_sample();
        chk("rstm_out_valid", out_valid, 0);
        chk("rstm_busy", busy, 0);
        chk("rstm_dp_issue", dp_issue, 0);
        step();
        out_ready = 1;
        d0 = deliv_cnt;
        repeat (8) step();
        chk("rstm_late_dropped", deliv_cnt - d0, 0);
        send(32'h40800000, 32'h40800000, 32'h40800000, 4'd9);
        wait_idle();
        chk("rstm_new_delivered", deliv_cnt - d0, 1);

        // Throughput: back-to-back normal ops
        out_ready = 1;
        i0 = issue_cnt;
        d0 = deliv_cnt;
        for (int k = 0; k < 8; k++) begin
            send(32'h3F800000 | (k << 12), 32'h40000000 | k, 32'h3E800000, 4'(k));
            iss_c[k] = cyc;
        end
        for (int k = 1; k < 8; k++) chk("tp_spacing", iss_c[k] - iss_c[k-1], 2);
        wait_idle();
        chk("tp_issues", issue_cnt - i0, 8);
        chk("tp_delivered", deliv_cnt - d0, 8);

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
